ber_checker: RTL and testbench
==============================

// Module: ber_checker
// PURPOSE
//  Receive-side BER meter downstream of TX_top.
//  Compares sliced RX bits with the TX PRBS reference bit stream.
//  Finds the TX->RX symbol delay automatically, locks to it, then counts received bits and bit errors.
//  Counters are read by the VIO/host for the BER figure.
// PARAMETERS
//  DLY_W    9    delay search width; max delay 2**DLY_W-1 = 511 (one PRBS9 period)
//  WIN      511  consecutive error-free strobes needed to declare lock
//  CNT_W    48   width of bit/error counters
//  LOL_THR  64   errors within one WIN-strobe window that force relock (BER_RELOCK_EN only)
// PORTS
//  clock        in   1      system clock
//  i_reset      in   1      asynchronous, active-high reset
//  i_enable     in   1      symbol strobe, 1-cycle pulse per symbol, same as TX rate divider
//  i_ref_bit    in   1      TX PRBS bit, valid when i_enable=1
//  i_rx_bit     in   1      sliced RX bit (sign of filter output), valid when i_enable=1
//  i_clear      in   1      synchronous clear of counters; restarts the search
//  o_lock       out  1      1 while state==LOCK
//  o_delay      out  DLY_W  current candidate / locked delay in strobes
//  o_bit_count  out  CNT_W  bits compared while locked
//  o_err_count  out  CNT_W  mismatches while locked
//  o_state      out  2      FSM state, for debug
// BEHAVIOUR
//  Reset: every output = 0, state=IDLE, delay line cleared, all internal counters 0.
//  i_reset may be asserted at any time, including mid-LOCK; it takes effect immediately.
//  All work happens only on clock edges with i_enable=1; i_enable=0 holds all state.
//  Delay line:
//   - ref_sr[2**DLY_W-2:0]; shifts in i_ref_bit on each strobe.
//   - Tap for d=0 is i_ref_bit; tap for d>0 is ref_sr[d-1].
//   - Compare rx(k) with ref(k-d): mismatch = i_rx_bit ^ tap(o_delay).
//  FSM (states encoded IDLE=0, SEARCH=1, LOCK=2):
//   IDLE:   count 2**DLY_W-1 strobes to fill the delay line, then go to SEARCH with delay=0.
//   SEARCH: on mismatch, delay <= delay+1 (wraps 511->0) and win_cnt <= 0.
//           Otherwise win_cnt++; the WIN-th consecutive match -> LOCK, delay held.
//   LOCK:   each strobe: bit_count++, err_count += mismatch.
//           When bit_count reaches all-ones, both counters freeze so the ratio stays valid.
//  Counters change only in LOCK; their values are retained on leaving LOCK.
//  Latency: all outputs are registered. Effects of strobe k are visible the cycle after edge k.
//  o_lock rises the cycle after the WIN-th match.
//  i_clear:
//   - Effect: counters=0, delay=0, win_cnt=0, state=SEARCH. The delay line is NOT flushed.
//   - Priority: overrides a simultaneous i_enable; that strobe is dropped (no shift, no count).
//   - In IDLE: the fill completes first; then clear acts as above.
// CONFIGURATION
//  BER_RELOCK_EN defined:
//   - LOCK also runs a WIN-strobe window counter with a per-window error count.
//   - The per-window count restarts each window.
//   - The count reaching LOL_THR inside one window -> SEARCH, delay+1, win_cnt=0.
//   - Accumulated counters are kept.
//  BER_RELOCK_EN undefined: LOCK is left only via i_reset or i_clear.
// STRUCTURE
//  ber_pkg.vh: state encodings (ST_IDLE/ST_SEARCH/ST_LOCK) and default widths.
//  Sub-module ber_ref_delay: shift register plus DLY_W-bit tap mux; output tap bit is combinational.
//  ber_checker holds the FSM, window counter and saturating counters.
// TESTING
//  1. PRBS9 ref; rx = ref delayed 37 strobes.
//     -> o_lock=1, o_delay=37, err_count=0; bit_count +1 per strobe.
//  2. Case 1 plus one rx bit flipped every 100 strobes in LOCK, 10000 strobes.
//     -> err_count=100, lock held (macro off).
//  3. Macro on; in LOCK, switch rx delay 37->200.
//     -> o_lock falls within WIN strobes, relocks with o_delay=200, counters continue from prior values.
//  4. i_clear pulsed coincident with i_enable in LOCK.
//     -> next cycle counters=0, o_state=SEARCH, o_delay=0; relocks to the same delay.
//  5. Boundaries: delay 0 and delay 511 both lock at the exact value.
//     Delay 511 wraps correctly from 511 to 0 on a further mismatch.
//     CNT_W=8 run for 300 locked strobes -> bit_count stuck at 255, err_count frozen.
//  6. i_reset asserted between clock edges mid-LOCK.
//     -> all outputs 0 immediately, o_state=IDLE; after release, full fill+search repeats.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared state encodings and default sizing for the BER checker.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCK   = 2'd2
    } ber_state_t;

    localparam int DEF_DLY_W   = 9;
    localparam int DEF_WIN     = 511;
    localparam int DEF_CNT_W   = 48;
    localparam int DEF_LOL_THR = 64;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// Reference-bit delay line: shift register of past strobed ref bits plus a
// combinational tap mux selecting the bit from 'delay' strobes ago (0 = current).
module ber_ref_delay
    import ber_pkg::*;
#(
    parameter int DLY_W = DEF_DLY_W
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             shift_en,
    input  logic             ref_bit,
    input  logic [DLY_W-1:0] delay,
    output logic             tap_bit
);

    localparam int LEN = 2**DLY_W - 1;

    logic [LEN-1:0] ref_sr_reg;
    logic [LEN:0]   taps;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            ref_sr_reg <= '0;
        end else if (shift_en) begin
            ref_sr_reg <= {ref_sr_reg[LEN-2:0], ref_bit};
        end
    end

    // taps[0] is the live bit, taps[d] is the bit shifted in d strobes ago.
    assign taps    = {ref_sr_reg, ref_bit};
    assign tap_bit = taps[delay];

endmodule

// File: rtl/ber_checker.sv
// BER meter: fills the reference delay line, searches for the TX->RX delay,
// locks, then counts compared bits and errors. Optional relock on loss of lock
// is built in when BER_RELOCK_EN is defined.
module ber_checker
    import ber_pkg::*;
#(
    parameter int DLY_W   = DEF_DLY_W,
    parameter int WIN     = DEF_WIN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LOL_THR = DEF_LOL_THR
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_ref_bit,
    input  logic             i_rx_bit,
    input  logic             i_clear,
    output logic             o_lock,
    output logic [DLY_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [1:0]       o_state
);

    localparam int WIN_W = cnt_bits(WIN);
    localparam int ERR_W = cnt_bits(LOL_THR);

    localparam logic [DLY_W-1:0] FILL_LAST = DLY_W'(2**DLY_W - 2);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(LOL_THR - 1);

    ber_state_t       state_reg,   state_next;
    logic [DLY_W-1:0] delay_reg,   delay_next;
    logic [DLY_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic [ERR_W-1:0] win_err_reg, win_err_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic clear_act;
    logic shift_en;
    logic tap_bit;
    logic mismatch;

    // A clear during the initial fill is ignored: the fill already lands in
    // SEARCH with zeroed counters and delay, which is exactly what clear does.
    assign clear_act = i_clear && (state_reg != ST_IDLE);
    assign shift_en  = i_enable && !clear_act;
    assign mismatch  = i_rx_bit ^ tap_bit;

    ber_ref_delay #(
        .DLY_W (DLY_W)
    ) u_ref_delay (
        .clock    (clock),
        .i_reset  (i_reset),
        .shift_en (shift_en),
        .ref_bit  (i_ref_bit),
        .delay    (delay_reg),
        .tap_bit  (tap_bit)
    );

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            delay_reg    <= '0;
            fill_cnt_reg <= '0;
            win_cnt_reg  <= '0;
            win_err_reg  <= '0;
            bit_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            delay_reg    <= delay_next;
            fill_cnt_reg <= fill_cnt_next;
            win_cnt_reg  <= win_cnt_next;
            win_err_reg  <= win_err_next;
            bit_cnt_reg  <= bit_cnt_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        delay_next    = delay_reg;
        fill_cnt_next = fill_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_err_next  = win_err_reg;
        bit_cnt_next  = bit_cnt_reg;
        err_cnt_next  = err_cnt_reg;

        if (clear_act) begin
            state_next   = ST_SEARCH;
            delay_next   = '0;
            win_cnt_next = '0;
            win_err_next = '0;
            bit_cnt_next = '0;
            err_cnt_next = '0;
        end else if (i_enable) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (fill_cnt_reg == FILL_LAST) begin
                        state_next    = ST_SEARCH;
                        delay_next    = '0;
                        fill_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 1'b1;
                    end
                end

                ST_SEARCH: begin
                    if (mismatch) begin
                        delay_next   = delay_reg + 1'b1;
                        win_cnt_next = '0;
                    end else if (win_cnt_reg == WIN_LAST) begin
                        // win_cnt is reused as the LOCK window position.
                        state_next   = ST_LOCK;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + 1'b1;
                    end
                end

                ST_LOCK: begin
                    // Both counters stop together so err/bit stays a valid ratio.
                    if (bit_cnt_reg != '1) begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        err_cnt_next = err_cnt_reg + CNT_W'(mismatch);
                    end
`ifdef BER_RELOCK_EN
                    if (mismatch && (win_err_reg == ERR_LAST)) begin
                        state_next   = ST_SEARCH;
                        delay_next   = delay_reg + 1'b1;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else if (win_cnt_reg == WIN_LAST) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + 1'b1;
                        win_err_next = win_err_reg + ERR_W'(mismatch);
                    end
`endif
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_lock      = (state_reg == ST_LOCK);
    assign o_delay     = delay_reg;
    assign o_bit_count = bit_cnt_reg;
    assign o_err_count = err_cnt_reg;
    assign o_state     = state_reg;

endmodule

// File: tb/tb_ber_checker.sv
// Scoreboard bench for ber_checker: two instances (48-bit and 8-bit counters)
// share randomized stimulus and are checked every cycle against a reference model.
module tb_ber_checker;

    localparam int NLINE = 511;
    localparam int WIN   = 511;
    localparam int LOL   = 64;
    localparam longint MAX48 = (64'd1 << 48) - 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic i_reset = 1'b1, i_enable = 1'b0, i_ref_bit = 1'b0, i_rx_bit = 1'b0, i_clear = 1'b0;

    logic        lock_a, lock_b;
    logic [8:0]  delay_a, delay_b;
    logic [47:0] bits_a, errs_a;
    logic [7:0]  bits_b, errs_b;
    logic [1:0]  state_a, state_b;

    ber_checker #(.DLY_W(9), .WIN(WIN), .CNT_W(48), .LOL_THR(LOL)) dut_a (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
        .i_rx_bit(i_rx_bit), .i_clear(i_clear), .o_lock(lock_a), .o_delay(delay_a),
        .o_bit_count(bits_a), .o_err_count(errs_a), .o_state(state_a));

    ber_checker #(.DLY_W(9), .WIN(WIN), .CNT_W(8), .LOL_THR(LOL)) dut_b (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
        .i_rx_bit(i_rx_bit), .i_clear(i_clear), .o_lock(lock_b), .o_delay(delay_b),
        .o_bit_count(bits_b), .o_err_count(errs_b), .o_state(state_b));

    typedef struct {
        bit     lock;
        int     dly;
        int     st;
        longint bits;
        longint errs;
        int     bits8;
        int     errs8;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0=idle 1=search 2=lock, history of strobed ref bits.
    int     m_ph, m_fill, m_dly, m_run, m_wpos, m_werr;
    longint m_bits, m_errs;
    int     m_bits8, m_errs8;
    bit     m_line[$];

    // Channel: ref source and history of transmitted ref bits (newest first).
    bit       chan[$];
    int       true_d = 37;
    bit       use_prbs = 1'b1;
    bit [8:0] lfsr = 9'h1FF;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic bit next_ref();
        bit b;
        if (use_prbs) begin
            b = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], b};
        end else begin
            b = 1'($urandom);
        end
        return b;
    endfunction

    function automatic bit rand_en();
        return $urandom_range(3) != 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_fill = 0; m_dly = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_bits = 0; m_errs = 0; m_bits8 = 0; m_errs8 = 0;
        m_line.delete();
    endtask

    task automatic model_step(input bit en, input bit clr, input bit r, input bit x);
        bit mis;
        if (clr && m_ph != 0) begin
            m_ph = 1; m_dly = 0; m_run = 0; m_wpos = 0; m_werr = 0;
            m_bits = 0; m_errs = 0; m_bits8 = 0; m_errs8 = 0;
            return;
        end
        if (!en) return;
        mis = x ^ ((m_dly == 0) ? r : ((m_dly - 1 < m_line.size()) ? m_line[m_dly - 1] : 1'b0));
        if (m_ph == 0) begin
            m_fill++;
            if (m_fill == NLINE) begin m_ph = 1; m_dly = 0; m_run = 0; end
        end else if (m_ph == 1) begin
            if (mis) begin
                m_dly = (m_dly + 1) % 512;
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == WIN) begin m_ph = 2; m_wpos = 0; m_werr = 0; end
            end
        end else begin
            if (m_bits < MAX48) begin m_bits++; m_errs += mis; end
            if (m_bits8 < 255) begin m_bits8++; m_errs8 += mis; end
`ifdef BER_RELOCK_EN
            m_werr += mis;
            m_wpos++;
            if (m_werr >= LOL) begin
                m_ph = 1; m_dly = (m_dly + 1) % 512; m_run = 0;
            end else if (m_wpos == WIN) begin
                m_wpos = 0; m_werr = 0;
            end
`endif
        end
        m_line.push_front(r);
        if (m_line.size() > NLINE) void'(m_line.pop_back());
    endtask

    // Drive one clock cycle at the falling edge and queue the expected result.
    task automatic step(input bit rst, input bit en, input bit clr, input bit flip_rx);
        bit r, x;
        @(negedge clock);
        if (en && !clr) begin
            r = next_ref();
            x = (true_d == 0) ? r : ((true_d - 1 < chan.size()) ? chan[true_d - 1] : 1'b0);
            chan.push_front(r);
            if (chan.size() > 600) void'(chan.pop_back());
        end else begin
            r = 1'($urandom);
            x = 1'($urandom);
        end
        x = x ^ flip_rx;
        i_reset = rst; i_enable = en; i_clear = clr; i_ref_bit = r; i_rx_bit = x;
        if (rst) model_reset();
        else     model_step(en, clr, r, x);
        exp_q.push_back('{m_ph == 2, m_dly, m_ph, m_bits, m_errs, m_bits8, m_errs8});
    endtask

    // Run n enabled strobes, flipping the rx bit on every flip_every-th one.
    task automatic strobes(input int n, input int flip_every);
        int k = 0;
        bit en;
        while (k < n) begin
            en = rand_en();
            step(1'b0, en, 1'b0, en && flip_every > 0 && ((k + 1) % flip_every == 0));
            if (en) k++;
        end
    endtask

    task automatic wait_lock(input string name, input int exp_d);
        int n = 0;
        while (m_ph != 2 && n < 8000) begin
            step(1'b0, rand_en(), 1'b0, 1'b0);
            n++;
        end
        @(posedge clock); #2;
        check({name, "_lock"}, longint'(lock_a), 1);
        check({name, "_delay"}, longint'(delay_a), exp_d);
    endtask

    // Monitor: one scoreboard comparison per clock, just after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (lock_a !== e.lock || delay_a !== 9'(e.dly) || state_a !== 2'(e.st) ||
                bits_a !== 48'(e.bits) || errs_a !== 48'(e.errs) ||
                lock_b !== e.lock || delay_b !== 9'(e.dly) || state_b !== 2'(e.st) ||
                bits_b !== 8'(e.bits8) || errs_b !== 8'(e.errs8)) begin
                n_fail++;
                $display("FAIL cycle t=%0t got lock=%0b dly=%0d st=%0d bits=%0d errs=%0d b8=%0d e8=%0d | expected lock=%0b dly=%0d st=%0d bits=%0d errs=%0d b8=%0d e8=%0d",
                         $time, lock_a, delay_a, state_a, bits_a, errs_a, bits_b, errs_b,
                         e.lock, e.dly, e.st, e.bits, e.errs, e.bits8, e.errs8);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint b0, e0;
        int n;
        model_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("reset_state", longint'(state_a), 0);
        check("reset_delay", longint'(delay_a), 0);
        check("reset_bits", longint'(bits_a), 0);

        // PRBS9 reference, rx delayed 37 strobes.
        use_prbs = 1'b1; true_d = 37;
        wait_lock("t1", 37);
        check("t1_errs", longint'(errs_a), 0);
        b0 = bits_a;
        strobes(300, 0);
        @(posedge clock); #2;
        check("t1_bits_step", longint'(bits_a), b0 + 300);
        check("t5_bits8_sat", longint'(bits_b), 255);

        // One flipped rx bit every 100 strobes over 10000 locked strobes.
        e0 = errs_a;
        strobes(10000, 100);
        @(posedge clock); #2;
        check("t2_err_delta", longint'(errs_a) - e0, 100);
        check("t2_lock_held", longint'(lock_a), 1);
        check("t5_errs8_frozen", longint'(errs_b), 0);

        // Clear coincident with a strobe while locked.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #2;
        check("t4_bits", longint'(bits_a), 0);
        check("t4_state", longint'(state_a), 1);
        check("t4_delay", longint'(delay_a), 0);
        wait_lock("t4_relock", 37);

`ifdef BER_RELOCK_EN
        b0 = bits_a;
        true_d = 200;
        n = 0;
        while (m_ph == 2 && n < 4 * WIN) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("t3_lol_within_win", longint'(n <= WIN), 1);
        @(posedge clock); #2;
        check("t3_lock_fell", longint'(lock_a), 0);
        wait_lock("t3_relock", 200);
        check("t3_counters_kept", longint'(bits_a > b0), 1);
`endif

        // Boundary delays with random reference data.
        use_prbs = 1'b0; true_d = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        wait_lock("t5_d0", 0);
        true_d = 511;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!(m_ph == 1 && m_dly == 511 && m_run >= 50) && n < 8000) begin
            step(1'b0, rand_en(), 1'b0, 1'b0);
            n++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clock); #2;
        check("t5_wrap_delay", longint'(delay_a), 0);
        check("t5_wrap_state", longint'(state_a), 1);
        wait_lock("t5_d511", 511);

        // Asynchronous reset between edges while locked.
        step(1'b0, rand_en(), 1'b0, 1'b0);
        @(posedge clock); #3;
        i_reset = 1'b1;
        #1;
        check("t6_lock", longint'(lock_a), 0);
        check("t6_state", longint'(state_a), 0);
        check("t6_delay", longint'(delay_a), 0);
        check("t6_bits", longint'(bits_a), 0);
        check("t6_errs", longint'(errs_a) + longint'(bits_b), 0);
        model_reset();
        exp_q.delete();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        wait_lock("t6_relock", 511);

        @(posedge clock); #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
